// File: rtl/vga_pkg.sv
// Shared constants for the VGA test-pattern source: default 640x480@60 timing,
// pattern mode encoding and the colour-bar palette.
package vga_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned BAR_WIDTH = 80;

    typedef enum logic [2:0] {
        ModeBlack   = 3'd0,
        ModeBars    = 3'd1,
        ModeXyf     = 3'd2,
        ModeChecker = 3'd3,
        ModeXor     = 3'd4,
        ModeWhite   = 3'd5,
        ModeRamp    = 3'd6,
        ModeDiag    = 3'd7
    } mode_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_source_if.sv
// Video bundle between the pattern source and its consumer (the dither stage).
// The source drives pixels/syncs and samples the pattern select.
interface vga_pattern_source_if;

    logic [2:0] mode;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  mode,
        output r, g, b, hsync, vsync, de, x, y, frame_start, frame_count
    );

    modport slave (
        output mode,
        input  r, g, b, hsync, vsync, de, x, y, frame_start, frame_count
    );

endinterface

// File: rtl/vga_timing.sv
// Raster counters for VGA timing: hc/vc, active-area and sync-window decode,
// and a strobe on the last clock of each frame.
module vga_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] o_hc,
    output logic [9:0] o_vc,
    output logic       o_active,
    output logic       o_hsync_on,
    output logic       o_vsync_on,
    output logic       o_frame_end
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       w_line_end;
    logic       w_frame_end;

    assign w_line_end  = (r_hc == H_LAST);
    assign w_frame_end = w_line_end && (r_vc == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_line_end) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    assign o_hc        = r_hc;
    assign o_vc        = r_vc;
    assign o_active    = (r_hc < H_VIS) && (r_vc < V_VIS);
    assign o_hsync_on  = (r_hc >= HS_FIRST) && (r_hc <= HS_LAST);
    assign o_vsync_on  = (r_vc >= VS_FIRST) && (r_vc <= VS_LAST);
    assign o_frame_end = w_frame_end;

endmodule

// File: rtl/vga_pattern_source.sv
// VGA test-pattern source: per-frame mode latch, frame counter, pattern mux
// and one output register stage that keeps RGB, syncs and DE pixel-aligned.
module vga_pattern_source
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    vga_pattern_source_if.master vid
);

    logic [9:0] w_hc;
    logic [9:0] w_vc;
    logic       w_active;
    logic       w_hsync_on;
    logic       w_vsync_on;
    logic       w_frame_end;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .o_hc        (w_hc),
        .o_vc        (w_vc),
        .o_active    (w_active),
        .o_hsync_on  (w_hsync_on),
        .o_vsync_on  (w_vsync_on),
        .o_frame_end (w_frame_end)
    );

    mode_e      r_mode;
    logic [7:0] r_frame_cnt;

    // Mode and count change together on the last clock of a frame, so pixel
    // (0,0) of the next frame is the first to see them.
    always_ff @(posedge clk) begin
        if (rst || w_frame_end) begin
            r_mode <= mode_e'(vid.mode);
        end
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    logic [7:0]  w_x8;
    logic [7:0]  w_y8;
    logic [7:0]  w_diag;
    logic [2:0]  w_bar;
    logic [23:0] w_rgb;

    assign w_x8   = w_hc[7:0];
    assign w_y8   = w_vc[7:0];
    assign w_diag = w_x8 + w_y8 + r_frame_cnt;
    assign w_bar  = 3'(w_hc / 10'(BAR_WIDTH));

    always_comb begin
        w_rgb = 24'h000000;
        if (w_active) begin
            unique case (r_mode)
                ModeBlack:   w_rgb = 24'h000000;
                ModeBars:    w_rgb = bar_colour(w_bar);
                ModeXyf:     w_rgb = {w_x8, w_y8, r_frame_cnt};
                ModeChecker: w_rgb = (w_hc[5] ^ w_vc[5]) ? 24'hFFFFFF : 24'h000000;
                ModeXor:     w_rgb = {w_x8 ^ w_y8, w_x8 + r_frame_cnt, w_y8};
                ModeWhite:   w_rgb = 24'hFFFFFF;
                ModeRamp:    w_rgb = {3{w_vc[8:1]}};
                ModeDiag:    w_rgb = {3{w_diag}};
                default:     w_rgb = 24'h000000;
            endcase
        end
    end

    logic [23:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_frame_start;
    logic [7:0]  r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb         <= '0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_rgb         <= w_rgb;
            r_hsync       <= w_hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= w_vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_de          <= w_active;
            r_x           <= w_hc;
            r_y           <= w_vc;
            r_frame_start <= (w_hc == 10'd0) && (w_vc == 10'd0);
            r_frame_count <= r_frame_cnt;
        end
    end

    assign vid.r           = r_rgb[23:16];
    assign vid.g           = r_rgb[15:8];
    assign vid.b           = r_rgb[7:0];
    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.de          = r_de;
    assign vid.x           = r_x;
    assign vid.y           = r_y;
    assign vid.frame_start = r_frame_start;
    assign vid.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Bench for vga_pattern_source: a wide instance (full line, short frame) and a tiny
// instance for frame-count wrap, both checked every cycle against a raster model.
module tb_vga_pattern_source;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic [7:0] fc;
    } out_t;

    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 34,  A_VF = 1,  A_VS = 2,  A_VB = 1;
    localparam int A_HT = A_HV + A_HF + A_HS + A_HB;
    localparam int A_FT = A_HT * (A_VV + A_VF + A_VS + A_VB);
    localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 3;
    localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;
    localparam int B_FT = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB);

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic [2:0] mode_a = 3'd1;
    logic [2:0] mode_b = 3'd2;
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_pattern_source_if vid_a ();
    vga_pattern_source_if vid_b ();
    assign vid_a.mode = mode_a;
    assign vid_b.mode = mode_b;

    vga_pattern_source #(
        .H_VISIBLE (A_HV), .H_FRONT (A_HF), .H_SYNC (A_HS), .H_BACK (A_HB),
        .V_VISIBLE (A_VV), .V_FRONT (A_VF), .V_SYNC (A_VS), .V_BACK (A_VB),
        .SYNC_ACTIVE (1'b0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vid (vid_a)
    );

    vga_pattern_source #(
        .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .SYNC_ACTIVE (1'b0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vid (vid_b)
    );

    out_t got_a, got_b;
    assign got_a = '{r: vid_a.r, g: vid_a.g, b: vid_a.b, hs: vid_a.hsync, vs: vid_a.vsync,
                     de: vid_a.de, x: vid_a.x, y: vid_a.y, fs: vid_a.frame_start,
                     fc: vid_a.frame_count};
    assign got_b = '{r: vid_b.r, g: vid_b.g, b: vid_b.b, hs: vid_b.hsync, vs: vid_b.vsync,
                     de: vid_b.de, x: vid_b.x, y: vid_b.y, fs: vid_b.frame_start,
                     fc: vid_b.frame_count};

    localparam out_t RST_OUT = '{r: 8'h0, g: 8'h0, b: 8'h0, hs: 1'b1, vs: 1'b1, de: 1'b0,
                                 x: 10'd0, y: 10'd0, fs: 1'b0, fc: 8'h0};

    // Output for the t-th clock after reset release, straight from the raster rules.
    function automatic out_t model_px(input int hv, input int hf, input int hsw, input int hb,
                                      input int vv, input int vf, input int vsw, input int vb,
                                      input int t, input int md);
        out_t o;
        int ht, vt, x, y, f;
        logic [23:0] c;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        x = t % ht;
        y = (t / ht) % vt;
        f = (t / (ht * vt)) % 256;
        c = 24'h0;
        if (x < hv && y < vv) begin
            case (md)
                1: c = bars[x / 80];
                2: c = 24'(((x % 256) * 65536) + ((y % 256) * 256) + f);
                3: c = ((((x / 32) ^ (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
                4: c = 24'((((x ^ y) % 256) * 65536) + (((x + f) % 256) * 256) + (y % 256));
                5: c = 24'hFFFFFF;
                6: c = 24'(((y / 2) % 256) * 65793);
                7: c = 24'(((x + y + f) % 256) * 65793);
                default: c = 24'h0;
            endcase
        end
        o.r = c[23:16];
        o.g = c[15:8];
        o.b = c[7:0];
        o.hs = (x >= hv + hf && x < hv + hf + hsw) ? 1'b0 : 1'b1;
        o.vs = (y >= vv + vf && y < vv + vf + vsw) ? 1'b0 : 1'b1;
        o.de = (x < hv && y < vv);
        o.x = 10'(x);
        o.y = 10'(y);
        o.fs = (x == 0 && y == 0);
        o.fc = 8'(f);
        return o;
    endfunction

    // Reference state per instance: clocks since release and the mode of the current frame.
    int t_a = 0, t_b = 0;
    int md_a = 0, md_b = 0;
    out_t exp_a, exp_b;
    logic valid_a = 1'b0, valid_b = 1'b0;
    logic last_rst_a = 1'b1;

    always @(posedge clk) begin
        valid_a    <= 1'b1;
        valid_b    <= 1'b1;
        last_rst_a <= rst_a;
        if (rst_a) begin
            exp_a <= RST_OUT;
            t_a   <= 0;
            md_a  <= int'(mode_a);
        end else begin
            exp_a <= model_px(A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, t_a, md_a);
            t_a   <= t_a + 1;
            if (t_a % A_FT == A_FT - 1) md_a <= int'(mode_a);
        end
        if (rst_b) begin
            exp_b <= RST_OUT;
            t_b   <= 0;
            md_b  <= int'(mode_b);
        end else begin
            exp_b <= model_px(B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, t_b, md_b);
            t_b   <= t_b + 1;
            if (t_b % B_FT == B_FT - 1) md_b <= int'(mode_b);
        end
    end

    task automatic chk_px(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at x=%0d y=%0d: got %h, expected %h", name, exp.x, exp.y, got, exp);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_a) chk_px("pixel_a", got_a, exp_a);
        if (valid_b) chk_px("pixel_b", got_b, exp_b);
    end

    // Whole-frame totals on instance A, between consecutive frame_start pulses.
    int cyc_c = 0, de_c = 0, hs_c = 0, vs_c = 0;
    logic have_prev = 1'b0;
    always @(negedge clk) begin
        if (last_rst_a) begin
            have_prev <= 1'b0;
        end else if (vid_a.frame_start) begin
            if (have_prev) begin
                check("frame_period", 32'(cyc_c), 32'(A_FT));
                check("de_per_frame", 32'(de_c), 32'(A_HV * A_VV));
                check("hsync_low_per_frame", 32'(hs_c), 32'(A_HS * (A_FT / A_HT)));
                check("vsync_low_per_frame", 32'(vs_c), 32'(A_HT * A_VS));
            end
            have_prev <= 1'b1;
            cyc_c <= 1;
            de_c  <= vid_a.de ? 1 : 0;
            hs_c  <= vid_a.hsync ? 0 : 1;
            vs_c  <= vid_a.vsync ? 0 : 1;
        end else begin
            cyc_c <= cyc_c + 1;
            de_c  <= de_c + (vid_a.de ? 1 : 0);
            hs_c  <= hs_c + (vid_a.hsync ? 0 : 1);
            vs_c  <= vs_c + (vid_a.vsync ? 0 : 1);
        end
    end

    task automatic wait_a(input int wx, input int wy);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(vid_a.x == 10'(wx) && vid_a.y == 10'(wy)) && n < 40000);
        if (n >= 40000) check("wait_a_timeout", 32'(wx), 32'(-1));
    endtask

    task automatic wait_fs(input bit inst_b, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(inst_b ? vid_b.frame_start : vid_a.frame_start) && n < limit);
        if (n >= limit) check("wait_frame_start_timeout", 32'(n), 32'(0));
    endtask

    task automatic run_a();
        logic [23:0] bar_exp [8];
        bar_exp = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        repeat (10) @(negedge clk);
        check("reset_outputs", 32'(got_a), 32'(RST_OUT));
        check("reset_sync_levels", {30'd0, vid_a.hsync, vid_a.vsync}, 32'h3);
        rst_a = 1'b0;
        @(negedge clk);
        check("first_xy", {12'd0, vid_a.x, vid_a.y}, 32'h0);
        check("first_fs_de", {30'd0, vid_a.frame_start, vid_a.de}, 32'h3);
        for (int k = 0; k < 8; k++) begin
            wait_a(80 * k, 5);
            check($sformatf("bar_%0d", k), {8'h0, vid_a.r, vid_a.g, vid_a.b}, {8'h0, bar_exp[k]});
        end
        wait_a(640, 5);
        check("x640_rgb_de", {7'h0, vid_a.de, vid_a.r, vid_a.g, vid_a.b}, 32'h0);
        wait_a(320, 10);
        mode_a = 3'd5;
        wait_a(321, 10);
        check("midframe_still_bars", {8'h0, vid_a.r, vid_a.g, vid_a.b}, 32'h00FF00FF);
        wait_fs(1'b0, 40000);
        check("next_frame_white", {vid_a.frame_count, vid_a.r, vid_a.g, vid_a.b}, 32'h01FFFFFF);
        begin
            int n;
            n = 0;
            do begin
                mode_a = 3'($urandom_range(0, 7));
                @(negedge clk);
                n++;
            end while (!vid_a.frame_start && n < 40000);
            check("frame2_count", {24'h0, vid_a.frame_count}, 32'h2);
        end
        wait_a(400, 20);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("midreset_outputs", 32'(got_a), 32'(RST_OUT));
        @(negedge clk);
        check("after_midreset", {vid_a.x, vid_a.y, vid_a.frame_start, vid_a.de, vid_a.frame_count},
              {10'd0, 10'd0, 1'b1, 1'b1, 8'd0});
        repeat (800) begin
            mode_a = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
    endtask

    task automatic run_b();
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 258; k++) begin
            wait_fs(1'b1, 4 * B_FT);
            check($sformatf("wrap_f%0d", k), {16'h0, vid_b.frame_count, vid_b.b},
                  {16'h0, 8'(k % 256), 8'(k % 256)});
        end
        repeat (40 * B_FT) begin
            mode_b = 3'($urandom_range(0, 7));
            rst_b  = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst_b = 1'b0;
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
